bit_serializer: RTL

- Parallel-to-serial stage that sits directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on dout, which drives the detector's din.
- Supports back-to-back words with no gap cycle.
- Drives IDLE_BIT on dout when it has no data to send, so the downstream detector sees a defined level.

---
 rtl/bit_serializer.sv | 86 ++++++++
 1 files changed

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial converter with valid/ready input handshake,
//               back-to-back words without gap cycles, IDLE_BIT when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_q;
    logic             word_done_q;

    logic             accept_d;
    logic             first_bit_d;
    logic             next_bit_d;
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] shift_d;

    // The first bit goes straight to the output flop; the shift register only
    // holds the bits still to come.
    assign first_bit_d = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign load_d      = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
    assign next_bit_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shift_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    assign in_ready = (state_q == S_IDLE) || (cnt_q == '0);
    assign accept_d = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dout_q      <= IDLE_BIT;
            word_done_q <= 1'b0;
        end else if (accept_d) begin
            state_q     <= S_SHIFT;
            shreg_q     <= load_d;
            cnt_q       <= LAST_IDX;
            dout_q      <= first_bit_d;
            word_done_q <= 1'b0;
        end else if (state_q == S_SHIFT && cnt_q != '0) begin
            shreg_q     <= shift_d;
            cnt_q       <= cnt_q - CW'(1);
            dout_q      <= next_bit_d;
            word_done_q <= (cnt_q == CW'(1));
        end else begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dout_q      <= IDLE_BIT;
            word_done_q <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == S_SHIFT);
    assign busy       = (state_q == S_SHIFT);
    assign word_done  = word_done_q;

endmodule
`default_nettype wire
